// File: rtl/fetch_req_ctrl_if.sv
// Fetch-stage / I-cache handshake bundle for fetch_req_ctrl.
// slave = controller side, master = fetch stage plus I-cache side.
interface fetch_req_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              stall;
  logic              flush;
  logic              core2icache_req;
  logic [ADDR_W-1:0] core2icache_addr;
  logic              icache2core_ready;
  logic [127:0]      icache2core_data;
  logic              icache2core_data_valid;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_addr;
  logic [127:0]      resp_data;
  logic [2:0]        outstanding;
  logic              err_unexpected;

  modport master (
    output req_valid, req_addr, stall, flush,
    output icache2core_ready, icache2core_data,
    output icache2core_data_valid,
    input  req_ready, core2icache_req, core2icache_addr,
    input  resp_valid, resp_addr, resp_data,
    input  outstanding, err_unexpected
  );

  modport slave (
    input  req_valid, req_addr, stall, flush,
    input  icache2core_ready, icache2core_data,
    input  icache2core_data_valid,
    output req_ready, core2icache_req, core2icache_addr,
    output resp_valid, resp_addr, resp_data,
    output outstanding, err_unexpected
  );
endinterface

// File: rtl/fetch_req_ctrl.sv
// In-order I-cache fetch request tracker with redirect draining.
// Optional FETCH_CTRL_PERF_EN adds issue/drop/stall perf counters.
module fetch_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic         clock,
  input  logic         reset,
  fetch_req_ctrl_if.slave bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_issue_cnt,
  output logic [31:0]  perf_drop_cnt,
  output logic [31:0]  perf_stall_cyc
`endif
);

  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]    DEPTH = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST  = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              stale;
  } entry_t;

  state_t        state;
  state_t        state_nx;
  entry_t        fifo [MAX_OUTSTANDING];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    count;
  logic [2:0]    count_nx;
  logic          err;
  logic          pop;
  logic          push;
  logic          head_stale;
  logic          can_issue;
  logic          resp_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_stale = fifo[head].stale;
    pop        = bus.icache2core_data_valid && (count != 3'd0);
    // a stale pop frees a slot but must not reopen issue this cycle
    can_issue  = (state == RUN) && !bus.stall && !bus.flush &&
                 ((count < DEPTH) || (pop && !head_stale));
    push       = bus.req_valid && can_issue && bus.icache2core_ready;
    resp_ok    = pop && !head_stale && (state == RUN) && !bus.flush;
    count_nx   = count + {2'b00, push} - {2'b00, pop};
  end

  assign bus.core2icache_req  = bus.req_valid && can_issue;
  assign bus.core2icache_addr = bus.req_addr;
  assign bus.req_ready        = push;
  assign bus.resp_valid       = resp_ok;
  assign bus.resp_addr        = fifo[head].addr;
  assign bus.resp_data        = bus.icache2core_data;
  assign bus.outstanding      = count;
  assign bus.err_unexpected   = err;

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:
        if (bus.flush && count_nx != 3'd0) state_nx = DRAIN;
      DRAIN:
        if (count_nx == 3'd0) state_nx = RUN;
      default:
        state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
      err   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        fifo[i] <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push) begin
        fifo[tail] <= '{addr: bus.req_addr, stale: 1'b0};
        tail       <= bump(tail);
      end
      if (pop)
        head <= bump(head);
      // flush never coincides with push, so marking every slot is safe
      if (bus.flush)
        for (int i = 0; i < MAX_OUTSTANDING; i++)
          fifo[i].stale <= 1'b1;
      if (bus.icache2core_data_valid && count == 3'd0)
        err <= 1'b1;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issue_cnt <= 32'd0;
      perf_drop_cnt  <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else begin
      if (push)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (pop && !resp_ok)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      if (bus.req_valid && !push)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed vector table plus randomized run against an epoch-based
// queue model of fetch_req_ctrl.
module tb_fetch_req_ctrl;

  localparam int MAX = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fetch_req_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_stall_cyc;
`endif

  fetch_req_ctrl #(
    .MAX_OUTSTANDING(MAX),
    .ADDR_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_drop_cnt(perf_drop_cnt),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        st;
    logic        fl;
    logic        rdy;
    logic        dv;
    logic        e_req;
    logic        e_rdy;
    logic        e_rv;
    logic [31:0] e_raddr;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } ment_t;

  vec_t  vq [$];
  ment_t mq [$];

  function automatic vec_t mk(
    input logic rv, input logic [31:0] addr,
    input logic st, input logic fl,
    input logic rdy, input logic dv,
    input logic e_req, input logic e_rdy,
    input logic e_rv, input logic [31:0] e_raddr,
    input logic [2:0] e_out, input logic e_err);
    vec_t v;
    v.rv = rv; v.addr = addr; v.st = st; v.fl = fl;
    v.rdy = rdy; v.dv = dv;
    v.e_req = e_req; v.e_rdy = e_rdy; v.e_rv = e_rv;
    v.e_raddr = e_raddr; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] addr,
                       input logic st, input logic fl,
                       input logic rdy, input logic dv,
                       input logic [127:0] data);
    bus.req_valid              = rv;
    bus.req_addr               = addr;
    bus.stall                  = st;
    bus.flush                  = fl;
    bus.icache2core_ready      = rdy;
    bus.icache2core_data_valid = dv;
    bus.icache2core_data       = data;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [127:0] data;
    int           cur_epoch;
    logic         m_err;
    logic         resp_in;
    logic         good;
    logic         draining;
    logic         e_req;
    logic         e_rdy;
    logic         rv, st, fl, rdy, dv;
    logic [31:0]  addr;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_ic_req", bus.core2icache_req, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_err", bus.err_unexpected, 0);
    reset = 1'b0;

    // basic fetch
    vq.push_back(mk(1,'h0,  0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(1,'h10, 0,0,1,0, 1,1,0,0,    1,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h0,  2,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h10, 1,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,0));
    // full limit
    vq.push_back(mk(1,'h20, 0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(1,'h30, 0,0,1,0, 1,1,0,0,    1,0));
    vq.push_back(mk(1,'h40, 0,0,1,0, 0,0,0,0,    2,0));
    vq.push_back(mk(1,'h40, 0,0,1,1, 1,1,1,'h20, 2,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    2,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h30, 2,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h40, 1,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,0));
    // redirect with two in flight
    vq.push_back(mk(1,'h50, 0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(1,'h60, 0,0,1,0, 1,1,0,0,    1,0));
    vq.push_back(mk(1,'h70, 0,1,1,0, 0,0,0,0,    2,0));
    vq.push_back(mk(1,'h100,0,0,1,0, 0,0,0,0,    2,0));
    vq.push_back(mk(1,'h100,0,0,1,1, 0,0,0,0,    2,0));
    vq.push_back(mk(1,'h100,0,0,1,1, 0,0,0,0,    1,0));
    vq.push_back(mk(1,'h100,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h100,1,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,0));
    // flush coincident with response
    vq.push_back(mk(1,'h200,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,1,1,1, 0,0,0,0,    1,0));
    vq.push_back(mk(1,'h210,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h210,1,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,0));
    // stall
    vq.push_back(mk(1,'h300,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(1,'h310,1,0,1,0, 0,0,0,0,    1,0));
    vq.push_back(mk(1,'h310,1,0,1,1, 0,0,1,'h300,1,0));
    vq.push_back(mk(1,'h310,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h310,1,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,0));
    // icache not ready
    vq.push_back(mk(1,'h400,0,0,0,0, 1,0,0,0,    0,0));
    vq.push_back(mk(1,'h400,0,0,1,0, 1,1,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h400,1,0));
    // unexpected response, sticky error, flush when empty
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,0,0,    0,0));
    vq.push_back(mk(0,'h0,  0,0,1,0, 0,0,0,0,    0,1));
    vq.push_back(mk(1,'h500,0,0,1,0, 1,1,0,0,    0,1));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h500,1,1));
    vq.push_back(mk(0,'h0,  0,1,1,0, 0,0,0,0,    0,1));
    vq.push_back(mk(1,'h510,0,0,1,0, 1,1,0,0,    0,1));
    vq.push_back(mk(0,'h0,  0,0,1,1, 0,0,1,'h510,1,1));

    foreach (vq[i]) begin
      data = {4{32'hC0DE_0000 | 32'(i)}};
      drive(vq[i].rv, vq[i].addr, vq[i].st, vq[i].fl,
            vq[i].rdy, vq[i].dv, data);
      #2;
      chk($sformatf("v%0d_ic_req", i),
          bus.core2icache_req, vq[i].e_req);
      chk($sformatf("v%0d_req_ready", i),
          bus.req_ready, vq[i].e_rdy);
      chk($sformatf("v%0d_resp_valid", i),
          bus.resp_valid, vq[i].e_rv);
      chk($sformatf("v%0d_outstanding", i),
          bus.outstanding, vq[i].e_out);
      chk($sformatf("v%0d_err", i),
          bus.err_unexpected, vq[i].e_err);
      if (vq[i].e_req)
        chk($sformatf("v%0d_ic_addr", i),
            bus.core2icache_addr, vq[i].addr);
      if (vq[i].e_rv) begin
        chk($sformatf("v%0d_resp_addr", i),
            bus.resp_addr, vq[i].e_raddr);
        chk($sformatf("v%0d_resp_data", i),
            bus.resp_data, data);
      end
      step();
    end

    // randomized run against the epoch model
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    step();
    reset = 1'b0;
    chk("rst2_err", bus.err_unexpected, 0);
    chk("rst2_outstanding", bus.outstanding, 0);
    cur_epoch = 0;
    m_err     = 1'b0;
    mq.delete();

    for (int c = 0; c < 2000; c++) begin
      rv   = ($urandom_range(99) < 70);
      addr = $urandom & 32'hFFFF_FFF0;
      st   = ($urandom_range(99) < 15);
      fl   = ($urandom_range(99) < 7);
      rdy  = ($urandom_range(99) < 75);
      if (mq.size() > 0)
        dv = ($urandom_range(99) < 45);
      else
        dv = ($urandom_range(99) < 2);
      data = {$urandom, $urandom, $urandom, $urandom};
      drive(rv, addr, st, fl, rdy, dv, data);

      draining = (mq.size() > 0) && (mq[0].epoch != cur_epoch);
      resp_in  = dv && (mq.size() > 0);
      good     = resp_in && !draining;
      e_req    = rv && !draining && !st && !fl &&
                 ((mq.size() < MAX) || good);
      e_rdy    = e_req && rdy;

      #2;
      chk("rnd_ic_req", bus.core2icache_req, e_req);
      chk("rnd_req_ready", bus.req_ready, e_rdy);
      chk("rnd_resp_valid", bus.resp_valid, good && !fl);
      chk("rnd_outstanding", bus.outstanding, 3'(mq.size()));
      chk("rnd_err", bus.err_unexpected, m_err);
      if (e_req)
        chk("rnd_ic_addr", bus.core2icache_addr, addr);
      if (good && !fl) begin
        chk("rnd_resp_addr", bus.resp_addr, mq[0].addr);
        chk("rnd_resp_data", bus.resp_data, data);
      end

      if (dv && mq.size() == 0)
        m_err = 1'b1;
      if (resp_in)
        void'(mq.pop_front());
      if (e_rdy)
        mq.push_back('{addr: addr, epoch: cur_epoch});
      if (fl)
        cur_epoch++;
      step();
    end

    // reset mid-operation, then a leftover response is unexpected
    drive(1, 'h40, 0, 0, 1, 0, '0);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    step();
    reset = 1'b0;
    chk("midrst_outstanding", bus.outstanding, 0);
    chk("midrst_err", bus.err_unexpected, 0);
    drive(0, 0, 0, 0, 1, 1, {4{32'hDEAD_BEEF}});
    #2;
    chk("midrst_resp_valid", bus.resp_valid, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, '0);
    #2;
    chk("midrst_err_set", bus.err_unexpected, 1);
    chk("midrst_out_zero", bus.outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
- Sequences instruction-fetch requests between the fetch stage and the I-cache port. Replaces the direct pc-to-icache wiring.
- Tracks up to MAX_OUTSTANDING in-flight 128-bit line requests in order, and returns each response tagged with its address.
- On a redirect (mispredict or backend flush), discards every response belonging to the old fetch stream, so only correct-path data reaches the fetch buffer.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of I-cache requests in flight (1..4).
- ADDR_W, 32, fetch address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch stage has an address to fetch
- req_addr  in  ADDR_W  16B-aligned fetch address
- req_ready  out  1  request accepted this cycle
- stall  in  1  fetch buffer cannot absorb more lines; blocks new issue
- flush  in  1  one-cycle redirect pulse; kills all in-flight requests
- core2icache_req  out  1  request strobe to I-cache
- core2icache_addr  out  ADDR_W  I-cache request address
- icache2core_ready  in  1  I-cache accepts the request this cycle
- icache2core_data  in  128  returned line (4 instructions)
- icache2core_data_valid  in  1  response beat; responses arrive in request order
- resp_valid  out  1  correct-path line valid to fetch stage
- resp_addr  out  ADDR_W  address of returned line
- resp_data  out  128  returned line
- outstanding  out  3  current in-flight count
- err_unexpected  out  1  sticky; a response arrived with no request in flight

Behaviour:
- Reset values:
  - req_ready = 0, core2icache_req = 0, resp_valid = 0.
  - outstanding = 0, err_unexpected = 0.
  - State = RUN; address FIFO empty; all stale bits clear.
- Tracking FIFO:
  - Depth MAX_OUTSTANDING; each entry = {addr, stale}.
  - Pointers wrap modulo depth.
  - count = outstanding.
- can_issue = state==RUN && !stall && !flush && (count < MAX_OUTSTANDING, or a non-stale pop happens this cycle).
- Issue path (combinational, zero latency):
  - core2icache_req = req_valid && can_issue.
  - core2icache_addr = req_addr.
  - req_ready = core2icache_req && icache2core_ready.
  - Accept = req_ready; on accept, push {req_addr, stale=0}.
- Response path:
  - On icache2core_data_valid with count > 0: pop the head entry.
  - resp_valid = valid && !head.stale && state==RUN, same cycle.
  - resp_addr = head.addr; resp_data = icache2core_data.
- Response with count == 0:
  - Ignored; resp_valid = 0; err_unexpected set.
  - err_unexpected clears only on reset.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed at full, except that a stale pop does not open issue in the same cycle.
- FSM:
  - RUN -> DRAIN on flush when count (after this cycle's push/pop) > 0. All remaining entries' stale bits are set.
  - RUN stays RUN on flush when count is 0.
  - DRAIN: no issue (core2icache_req = 0). Every response pops silently with resp_valid = 0.
  - DRAIN -> RUN when the last stale entry pops (count reaches 0).
  - Flush while already in DRAIN: no effect beyond keeping entries stale.
- Flush priority:
  - A flush in the same cycle as a response drops that response (resp_valid = 0).
  - A flush blocks issue that cycle, so no accept coincides with flush.
- stall only gates issue. Responses already in flight are always delivered, so the fetch buffer must reserve MAX_OUTSTANDING free slots before deasserting stall.
- Reset mid-operation:
  - FIFO and state cleared next edge.
  - The I-cache is reset in the same cycle; responses after reset with count 0 are flagged as unexpected.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, adds three outputs:
  - perf_issue_cnt (32): count of accepts.
  - perf_drop_cnt (32): count of responses discarded as stale.
  - perf_stall_cyc (32): count of cycles with req_valid && !req_ready.
- Counters reset to 0 and wrap at 2^32.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Basic fetch: req 0x0, 0x10 back-to-back, icache ready, responses at +2 and +3 cycles -> resp_valid twice with resp_addr 0x0 then 0x10; outstanding peaks at 2 and returns to 0.
- Full limit: 2 accepted, no response yet, req_valid = 1 -> req_ready = 0; on the response cycle a third request is accepted and outstanding stays 2.
- Redirect: 2 in flight, flush pulse -> state DRAIN, core2icache_req = 0; both responses give resp_valid = 0; RUN resumes and a new req 0x100 is accepted the cycle after the last pop.
- Flush coincident with response: 1 in flight, data_valid and flush in the same cycle -> resp_valid = 0; outstanding 0; state stays RUN.
- Stall: stall = 1 with 1 in flight -> no issue, yet the response is still delivered with resp_valid = 1; issue resumes the cycle stall drops.
- Unexpected response: data_valid with outstanding 0 -> resp_valid = 0, err_unexpected = 1 and held until reset; with FETCH_CTRL_PERF_EN, perf_drop_cnt = 2 after the redirect scenario.
